// File: rtl/aes_ecb_dec_seq.sv
// aes_ecb_dec_seq: multi-block AES-128 ECB decrypt sequencer.
// Accepts one request (key + NBLK ciphertext blocks). It feeds the blocks in order,
// block 0 first, to a single-block decrypt core. It gathers the plaintext blocks and
// returns the whole result on a valid/ready response channel.
//
// Parameters:
//   NBLK    - 128-bit blocks per request (>= 1)
//   TIMEOUT - per-block cycle limit while waiting on the core (timeout build only)
//
// Optional feature macro: AES_ECB_SEQ_TIMEOUT_EN
//   defined     - per-block timer; a stalled core ends the request with rsp_err = 1
//   not defined - no timer; rsp_err is tied 0 and the core is awaited indefinitely
//
// Ports:
//   clk, rst                          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_key, req_data                 key and ciphertext; block 0 = req_data MSBs
//   rsp_valid/rsp_ready               response handshake (held until accepted)
//   rsp_data, rsp_err                 plaintext (same block order), core timeout flag
//   core_valid/core_ready             block issue handshake
//   core_key, core_din                key and ciphertext block being issued
//   core_dout_valid, core_dout        one-cycle result pulse and decrypted block
module aes_ecb_dec_seq #(
  parameter int unsigned NBLK    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [127:0]         req_key,
  input  logic [NBLK*128-1:0]  req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NBLK*128-1:0]  rsp_data,
  output logic                 rsp_err,
  output logic                 core_valid,
  input  logic                 core_ready,
  output logic [127:0]         core_key,
  output logic [127:0]         core_din,
  input  logic                 core_dout_valid,
  input  logic [127:0]         core_dout
);

  localparam int unsigned DW = NBLK * 128;
  localparam int unsigned IW = (NBLK > 1) ? $clog2(NBLK) : 1;

  // Elaboration-time parameter sanity check
  if (NBLK < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("aes_ecb_dec_seq: NBLK and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   data_q;
  logic [127:0]    blk_next_c;
  logic            last_c;

  assign last_c = (idx == IW'(NBLK - 1));

  // Ciphertext block idx+1 of the captured request (value unused on the last block)
  always_comb begin
    blk_next_c = '0;
    for (int i = 0; i < NBLK; i++) begin
      if (IW'(i) == idx + IW'(1)) blk_next_c = data_q[DW-1-128*i -: 128];
    end
  end

`ifdef AES_ECB_SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] timer;
  logic          tmo_c;
  assign tmo_c = (timer == TW'(TIMEOUT));
`else
  assign rsp_err = 1'b0;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      data_q     <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      core_valid <= 1'b0;
      core_key   <= '0;
      core_din   <= '0;
`ifdef AES_ECB_SEQ_TIMEOUT_EN
      rsp_err    <= 1'b0;
      timer      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state      <= ISSUE;
            req_ready  <= 1'b0;
            core_key   <= req_key;
            data_q     <= req_data;
            rsp_data   <= '0;
            idx        <= '0;
            core_valid <= 1'b1;
            core_din   <= req_data[DW-1 -: 128];
`ifdef AES_ECB_SEQ_TIMEOUT_EN
            rsp_err    <= 1'b0;
            timer      <= '0;
`endif
          end else begin
            req_ready <= 1'b1;
          end
        end

        ISSUE: begin
          if (core_ready) begin
            core_valid <= 1'b0;
            state      <= WAIT;
`ifdef AES_ECB_SEQ_TIMEOUT_EN
            timer      <= timer + TW'(1);
          end else if (tmo_c) begin
            core_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + TW'(1);
`endif
          end
        end

        WAIT: begin
          if (core_dout_valid) begin
            for (int i = 0; i < NBLK; i++) begin
              if (idx == IW'(i)) rsp_data[DW-1-128*i -: 128] <= core_dout;
            end
            if (last_c) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              idx        <= idx + IW'(1);
              core_din   <= blk_next_c;
              core_valid <= 1'b1;
              state      <= ISSUE;
`ifdef AES_ECB_SEQ_TIMEOUT_EN
              timer      <= '0;
`endif
            end
`ifdef AES_ECB_SEQ_TIMEOUT_EN
          end else if (tmo_c) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + TW'(1);
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ecb_dec_seq.sv
// Directed bench for aes_ecb_dec_seq (NBLK=2 and NBLK=1 instances, TIMEOUT=8),
// using NIST SP800-38A ECB-AES128 vectors and a lookup-table model of the block core.
module tb_aes_ecb_dec_seq;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT0 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CT1 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NBLK=2 instance
  logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [127:0] req_key, core_key, core_din, core_dout;
  logic [255:0] req_data, rsp_data;
  logic         core_valid, core_ready, core_dout_valid;

  // NBLK=1 instance
  logic         req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [127:0] req_key1, core_key1, core_din1, core_dout1;
  logic [127:0] req_data1, rsp_data1;
  logic         core_valid1, core_ready1, core_dout_valid1;

  aes_ecb_dec_seq #(.NBLK(2), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_valid(core_valid), .core_ready(core_ready), .core_key(core_key), .core_din(core_din),
    .core_dout_valid(core_dout_valid), .core_dout(core_dout)
  );

  aes_ecb_dec_seq #(.NBLK(1), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_key(req_key1), .req_data(req_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .core_valid(core_valid1), .core_ready(core_ready1), .core_key(core_key1), .core_din(core_din1),
    .core_dout_valid(core_dout_valid1), .core_dout(core_dout1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Known-answer table standing in for the AES block decrypt
  function automatic logic [127:0] lut(input logic [127:0] ct, input logic [127:0] key);
    if (key != KEY)      return 128'h0bad_0bad_0bad_0bad_0bad_0bad_0bad_0bad;
    else if (ct == CT0)  return PT0;
    else if (ct == CT1)  return PT1;
    else                 return 128'hdead_dead_dead_dead_dead_dead_dead_dead;
  endfunction

  // Core model knobs and observations (NBLK=2 instance)
  int           stall_n    = 0;
  int           mute_from  = 99;
  int           acc_cnt    = 0;
  int           stall_viol = 0;
  bit           stray      = 1'b0;
  logic [127:0] issued[$];

  initial begin : core_model
    int           stall_cnt;
    int           cap_idx;
    bit           acc_pend;
    bit           stalled;
    logic [127:0] din_cap, key_cap, stall_din;
    stall_cnt = 0; cap_idx = 0; acc_pend = 0; stalled = 0;
    din_cap = '0; key_cap = '0; stall_din = '0;
    core_ready = 1'b0; core_dout_valid = 1'b0; core_dout = '0;
    forever begin
      @(posedge clk); #1;
      core_dout_valid = 1'b0;
      if (acc_pend) begin
        acc_pend = 0;
        if (cap_idx < mute_from) begin
          core_dout_valid = 1'b1;
          core_dout       = lut(din_cap, key_cap);
        end
      end
      if (stray) begin
        stray           = 1'b0;
        core_dout_valid = 1'b1;
        core_dout       = '1;
      end
      if (rst) begin
        core_ready = 1'b0; stall_cnt = 0; stalled = 0;
      end else if (core_valid) begin
        if (stalled && core_din !== stall_din) stall_viol++;
        if (stall_cnt < stall_n) begin
          core_ready = 1'b0; stall_cnt++; stalled = 1; stall_din = core_din;
        end else begin
          core_ready = 1'b1; acc_pend = 1; din_cap = core_din; key_cap = core_key;
          issued.push_back(core_din); cap_idx = acc_cnt; acc_cnt++;
          stall_cnt = 0; stalled = 0;
        end
      end else begin
        core_ready = 1'b0; stalled = 0;
      end
    end
  end

  // Zero-wait core model for the NBLK=1 instance
  initial begin : core_model1
    bit           pend;
    logic [127:0] cap, kcap;
    pend = 0; cap = '0; kcap = '0;
    core_ready1 = 1'b0; core_dout_valid1 = 1'b0; core_dout1 = '0;
    forever begin
      @(posedge clk); #1;
      core_dout_valid1 = pend;
      core_dout1       = pend ? lut(cap, kcap) : '0;
      pend             = 0;
      if (core_valid1 && !rst) begin
        core_ready1 = 1'b1; pend = 1; cap = core_din1; kcap = core_key1;
      end else begin
        core_ready1 = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a request and return just after the accepting edge
  task automatic send_req(input logic [127:0] key, input logic [255:0] data);
    int k;
    req_key = key; req_data = data; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    chk("req_ready_before_accept", 256'(req_ready), 256'(1));
    step();
    req_valid = 1'b0;
    req_key   = ~key;
    req_data  = ~data;
  endtask

  // Edges counted from the accept edge (inclusive) until rsp_valid is visible
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin step(); lat++; end
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_handshake", 256'(rsp_valid), 256'(0));
    chk("req_ready_after_handshake", 256'(req_ready), 256'(1));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int seen;
    rst = 1'b1;
    req_valid = 0; req_key = '0; req_data = '0; rsp_ready = 0;
    req_valid1 = 0; req_key1 = '0; req_data1 = '0; rsp_ready1 = 0;

    // Reset values
    step();
    chk("rst_req_ready",  256'(req_ready),  256'(0));
    chk("rst_rsp_valid",  256'(rsp_valid),  256'(0));
    chk("rst_rsp_data",   rsp_data,         256'(0));
    chk("rst_rsp_err",    256'(rsp_err),    256'(0));
    chk("rst_core_valid", 256'(core_valid), 256'(0));
    chk("rst_core_key",   256'(core_key),   256'(0));
    chk("rst_core_din",   256'(core_din),   256'(0));
    step();
    rst = 1'b0;
    step();
    chk("idle_req_ready", 256'(req_ready), 256'(1));

    // 1: NIST two-block decrypt, zero-wait core
    acc_cnt = 0; issued.delete();
    send_req(KEY, {CT0, CT1});
    chk("t1_core_valid_issue", 256'(core_valid), 256'(1));
    chk("t1_core_din_blk0",    256'(core_din),   256'(CT0));
    chk("t1_core_key",         256'(core_key),   256'(KEY));
    wait_rsp(lat);
    chk("t1_latency",   256'(lat),       256'(5));
    chk("t1_rsp_data",  rsp_data,        {PT0, PT1});
    chk("t1_rsp_err",   256'(rsp_err),   256'(0));
    chk("t1_req_ready", 256'(req_ready), 256'(0));
    rsp_handshake();

    // 2: core backpressure, 3 stall cycles per block
    stall_n = 3; acc_cnt = 0; issued.delete(); stall_viol = 0;
    send_req(KEY, {CT0, CT1});
    wait_rsp(lat);
    stall_n = 0;
    chk("t2_latency",     256'(lat),          256'(11));
    chk("t2_rsp_data",    rsp_data,           {PT0, PT1});
    chk("t2_issued_cnt",  256'(issued.size()), 256'(2));
    chk("t2_issued_0",    256'(issued[0]),    256'(CT0));
    chk("t2_issued_1",    256'(issued[1]),    256'(CT1));
    chk("t2_din_stable",  256'(stall_viol),   256'(0));
    rsp_handshake();

    // 3: response backpressure with a second request pending
    acc_cnt = 0;
    send_req(KEY, {CT1, CT0});
    wait_rsp(lat);
    chk("t3_latency", 256'(lat), 256'(5));
    req_valid = 1'b1; req_key = KEY; req_data = {CT0, CT1};
    for (int c = 0; c < 4; c++) begin
      chk("t3_hold_rsp_valid", 256'(rsp_valid), 256'(1));
      chk("t3_hold_rsp_data",  rsp_data,        {PT1, PT0});
      chk("t3_hold_req_ready", 256'(req_ready), 256'(0));
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t3_rsp_valid_drop", 256'(rsp_valid), 256'(0));
    chk("t3_req_ready_idle", 256'(req_ready), 256'(1));
    step();
    req_valid = 1'b0; req_data = '0;
    chk("t3_second_accepted", 256'(req_ready), 256'(0));
    wait_rsp(lat);
    chk("t3_second_latency", 256'(lat), 256'(5));
    chk("t3_second_data",    rsp_data,  {PT0, PT1});
    rsp_handshake();

    // 4: reset during WAIT of block 1, stray result in IDLE, then fresh request
    acc_cnt = 0;
    send_req(KEY, {CT0, CT1});
    step(); step(); step();
    chk("t4_in_wait_blk1", 256'(core_din), 256'(CT1));
    rst = 1'b1;
    #1;
    chk("t4_async_core_din", 256'(core_din),  256'(0));
    chk("t4_async_rsp_data", rsp_data,        256'(0));
    step();
    chk("t4_rst_req_ready",  256'(req_ready),  256'(0));
    chk("t4_rst_rsp_valid",  256'(rsp_valid),  256'(0));
    chk("t4_rst_core_valid", 256'(core_valid), 256'(0));
    chk("t4_rst_core_key",   256'(core_key),   256'(0));
    chk("t4_rst_rsp_data",   rsp_data,         256'(0));
    rst = 1'b0;
    step();
    stray = 1'b1;
    step();
    step();
    chk("t4_stray_rsp_data",  rsp_data,        256'(0));
    chk("t4_stray_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("t4_stray_req_ready", 256'(req_ready), 256'(1));
    acc_cnt = 0;
    send_req(KEY, {CT0, CT1});
    wait_rsp(lat);
    chk("t4_fresh_latency", 256'(lat), 256'(5));
    chk("t4_fresh_data",    rsp_data,  {PT0, PT1});
    rsp_handshake();

    // 5: core never answers block 1
    mute_from = 1; acc_cnt = 0;
    send_req(KEY, {CT0, CT1});
`ifdef AES_ECB_SEQ_TIMEOUT_EN
    wait_rsp(lat);
    chk("t5_latency",    256'(lat),        256'(12));
    chk("t5_rsp_valid",  256'(rsp_valid),  256'(1));
    chk("t5_rsp_err",    256'(rsp_err),    256'(1));
    chk("t5_rsp_data",   rsp_data,         {PT0, 128'h0});
    chk("t5_core_valid", 256'(core_valid), 256'(0));
    rsp_handshake();
    mute_from = 99;
`else
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid) seen++;
      step();
    end
    chk("t5_no_rsp",  256'(seen),    256'(0));
    chk("t5_rsp_err", 256'(rsp_err), 256'(0));
    mute_from = 99;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t5_recover_req_ready", 256'(req_ready), 256'(1));
`endif

    // 6: NBLK=1 instance, single block
    req_key1 = KEY; req_data1 = CT0; req_valid1 = 1'b1;
    seen = 0;
    while (!req_ready1 && seen < 50) begin step(); seen++; end
    chk("t6_req_ready1", 256'(req_ready1), 256'(1));
    step();
    req_valid1 = 1'b0; req_data1 = '0; req_key1 = '0;
    lat = 1;
    while (!rsp_valid1 && lat < 200) begin step(); lat++; end
    chk("t6_latency",  256'(lat),      256'(3));
    chk("t6_rsp_data", 256'(rsp_data1), 256'(PT0));
    chk("t6_rsp_err",  256'(rsp_err1),  256'(0));
    rsp_ready1 = 1'b1;
    step();
    rsp_ready1 = 1'b0;
    chk("t6_rsp_valid_drop", 256'(rsp_valid1), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
